// File: rtl/flash_streamer_pkg.sv
// Shared types and constants for the flash sample streamer.
package flash_streamer_pkg;

    localparam int unsigned DEF_DATA_WIDTH_BYTES = 4;
    localparam int unsigned DEF_SAMPLE_BITS      = 8;

    function automatic int unsigned spw_of(input int unsigned data_bytes, input int unsigned sample_bits);
        return (data_bytes * 8) / sample_bits;
    endfunction

    localparam int unsigned SPW = spw_of(DEF_DATA_WIDTH_BYTES, DEF_SAMPLE_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FETCH = 3'd2,
        HOLD  = 3'd3,
        CONT  = 3'd4,
        STOP  = 3'd5,
        DONE  = 3'd6
    } stream_state_e;

endpackage

// File: rtl/sample_word_buffer.sv
// Play/prefetch double buffer: shifts samples out MSB first, bypasses captures
// straight into the play register when it is empty or draining, flags underrun.
module sample_word_buffer
    import flash_streamer_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS      = 8,
    parameter int unsigned SAMPLES_PER_WORD = SPW
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   clr_underrun,
    input  logic                                   capture,
    input  logic [SAMPLE_BITS*SAMPLES_PER_WORD-1:0] cap_data,
    input  logic                                   strobe,
    input  logic                                   active,
    output logic [SAMPLE_BITS-1:0]                 sample_out,
    output logic                                   sample_valid,
    output logic                                   underrun,
    output logic                                   empty_c,
    output logic                                   pref_free_c
);

    localparam int unsigned WORD_W = SAMPLE_BITS * SAMPLES_PER_WORD;
    localparam int unsigned IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

    logic [WORD_W-1:0] play_sr;
    logic [WORD_W-1:0] pref_word;
    logic [IDX_W-1:0]  idx;
    logic              play_valid;
    logic              pref_valid;
    logic              consume_c;
    logic              last_c;

    assign consume_c    = strobe && play_valid;
    assign last_c       = consume_c && (idx == IDX_W'(SAMPLES_PER_WORD - 1));
    assign empty_c      = !play_valid && !pref_valid;
    assign pref_free_c  = !pref_valid || last_c;
    assign sample_out   = play_sr[WORD_W-1 -: SAMPLE_BITS];
    assign sample_valid = play_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_sr    <= '0;
            pref_word  <= '0;
            idx        <= '0;
            play_valid <= 1'b0;
            pref_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (clr_underrun) begin
                underrun <= 1'b0;
            end else if (strobe && !play_valid && active) begin
                underrun <= 1'b1;
            end

            if (flush) begin
                play_sr    <= '0;
                idx        <= '0;
                play_valid <= 1'b0;
                pref_valid <= 1'b0;
            end else if (last_c || !play_valid) begin
                // play slot frees this cycle: prefetch moves up, else a capture bypasses in
                idx <= '0;
                if (last_c && pref_valid) begin
                    play_sr    <= pref_word;
                    play_valid <= 1'b1;
                    pref_valid <= capture;
                    if (capture) begin
                        pref_word <= cap_data;
                    end
                end else if (capture) begin
                    play_sr    <= cap_data;
                    play_valid <= 1'b1;
                end else begin
                    play_sr    <= '0;
                    play_valid <= 1'b0;
                end
            end else begin
                if (consume_c) begin
                    play_sr <= play_sr << SAMPLE_BITS;
                    idx     <= idx + IDX_W'(1);
                end
                if (capture) begin
                    pref_word  <= cap_data;
                    pref_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flash_sample_streamer.sv
// Sequences start/continue/stop reads from the SPI flash controller and feeds a
// sample double buffer. Define STREAMER_LOOP_EN to replay the run continuously.
module flash_sample_streamer
    import flash_streamer_pkg::*;
#(
    parameter int unsigned ADDR_BITS        = 16,
    parameter int unsigned DATA_WIDTH_BYTES = DEF_DATA_WIDTH_BYTES,
    parameter int unsigned SAMPLE_BITS      = DEF_SAMPLE_BITS,
    parameter int unsigned LEN_BITS         = 12,
    parameter int unsigned STOP_HOLD        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [ADDR_BITS-1:0]          base_addr,
    input  logic [LEN_BITS-1:0]           length_words,
    input  logic                          sample_strobe,
    output logic [SAMPLE_BITS-1:0]        sample_out,
    output logic                          sample_valid,
    output logic                          playing,
    output logic                          underrun,
    output logic                          done,
    output logic [ADDR_BITS-1:0]          flash_addr,
    output logic                          flash_start_read,
    output logic                          flash_continue_read,
    output logic                          flash_stop_read,
    input  logic [DATA_WIDTH_BYTES*8-1:0] flash_data,
    input  logic                          flash_busy
);

    localparam int unsigned STOP_W = $clog2(STOP_HOLD + 1);

    stream_state_e       state, state_d;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] fetched;
    logic [LEN_BITS-1:0] fetched_inc;
    logic [STOP_W-1:0]   stop_cnt;
    logic                busy_q;
    logic                done_sent;
    logic                capture_c, flush_c, clr_underrun_c, latch_c, fetched_clr_c;
    logic                stop_done_c, done_c, active_c, buf_empty_c, pref_free_c;

    assign fetched_inc = fetched + LEN_BITS'(1);
    assign capture_c   = (state == FETCH) && busy_q && !flash_busy;
    assign stop_done_c = (stop_cnt == STOP_W'(STOP_HOLD - 1));
    assign active_c    = (state != IDLE) && (state != DONE);
    assign done_c      = (state == DONE) && buf_empty_c && !done_sent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state; an early enable drop lets the in-flight word land, then flushes
    always_comb begin
        state_d        = state;
        latch_c        = 1'b0;
        clr_underrun_c = 1'b0;
        flush_c        = 1'b0;
        fetched_clr_c  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    latch_c        = 1'b1;
                    clr_underrun_c = 1'b1;
                    state_d        = (length_words == '0) ? DONE : START;
                end
            end
            START, CONT: begin
                if (flash_busy) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (capture_c) begin
                    if (!enable) begin
                        state_d = STOP;
                        flush_c = 1'b1;
                    end else if (fetched_inc == len_q) begin
                        state_d = STOP;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = STOP;
                    flush_c = 1'b1;
                end else if (pref_free_c) begin
                    state_d = CONT;
                end
            end
            STOP: begin
                if (stop_done_c) begin
                    if (!enable || (fetched != len_q)) begin
                        state_d = IDLE;
                    end else begin
`ifdef STREAMER_LOOP_EN
                        // restart only once the prefetch slot can take the next word
                        if (pref_free_c) begin
                            state_d       = START;
                            fetched_clr_c = 1'b1;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q               <= '0;
            fetched             <= '0;
            stop_cnt            <= '0;
            busy_q              <= 1'b0;
            done_sent           <= 1'b0;
            flash_addr          <= '0;
            flash_start_read    <= 1'b0;
            flash_continue_read <= 1'b0;
            flash_stop_read     <= 1'b0;
            playing             <= 1'b0;
            done                <= 1'b0;
        end else begin
            busy_q <= flash_busy;
            if (latch_c) begin
                len_q      <= length_words;
                flash_addr <= base_addr;
            end
            if (latch_c || fetched_clr_c) begin
                fetched <= '0;
            end else if (capture_c) begin
                fetched <= fetched_inc;
            end
            if (state_d != STOP) begin
                stop_cnt <= '0;
            end else if ((state == STOP) && !stop_done_c) begin
                stop_cnt <= stop_cnt + STOP_W'(1);
            end
            if (state_d == IDLE) begin
                done_sent <= 1'b0;
            end else if (done_c) begin
                done_sent <= 1'b1;
            end
            flash_start_read    <= (state_d == START);
            flash_continue_read <= (state_d == CONT);
            flash_stop_read     <= (state_d == STOP);
            playing             <= (state_d != IDLE);
            done                <= done_c;
        end
    end

    sample_word_buffer #(
        .SAMPLE_BITS      (SAMPLE_BITS),
        .SAMPLES_PER_WORD (spw_of(DATA_WIDTH_BYTES, SAMPLE_BITS))
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_c),
        .clr_underrun (clr_underrun_c),
        .capture      (capture_c),
        .cap_data     (flash_data),
        .strobe       (sample_strobe),
        .active       (active_c),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .empty_c      (buf_empty_c),
        .pref_free_c  (pref_free_c)
    );

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Bench for flash_sample_streamer with a behavioural SPI flash controller model.
module tb_flash_sample_streamer;

    localparam int unsigned SPW       = 4;
    localparam int unsigned STOP_HOLD = 8;
    localparam int unsigned LAT       = 5;
    localparam int unsigned GOT_MAX   = 8192;

    typedef struct {
        logic [15:0] base;
        int          len;
        int          period;
        int          mode;      // 1 = every period cycles, 2 = random 1/period
        bit          early;     // strobe from enable rather than from first valid sample
        int          exp_start;
        int          exp_cont;
        int          exp_und;   // -1 = don't care
    } case_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] base_addr;
    logic [11:0] length_words;
    logic        sample_strobe;
    logic [7:0]  sample_out;
    logic        sample_valid, playing, underrun, done;
    logic [15:0] flash_addr;
    logic        flash_start_read, flash_continue_read, flash_stop_read;
    logic [31:0] flash_data;
    logic        flash_busy;

    always #5 clk = ~clk;

    flash_sample_streamer u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .base_addr           (base_addr),
        .length_words        (length_words),
        .sample_strobe       (sample_strobe),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .playing             (playing),
        .underrun            (underrun),
        .done                (done),
        .flash_addr          (flash_addr),
        .flash_start_read    (flash_start_read),
        .flash_continue_read (flash_continue_read),
        .flash_stop_read     (flash_stop_read),
        .flash_data          (flash_data),
        .flash_busy          (flash_busy)
    );

    // controller model: requests sampled on a divide-by-8 tick, big-endian sequential words
    logic [7:0]  mem [0:65535];
    logic [2:0]  div;
    logic [3:0]  lat;
    logic [15:0] ptr;
    int          n_words = 0;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem[a], mem[16'(a + 16'd1)], mem[16'(a + 16'd2)], mem[16'(a + 16'd3)]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            lat        <= '0;
            ptr        <= '0;
            flash_busy <= 1'b0;
            flash_data <= '0;
        end else begin
            div <= div + 3'd1;
            if (flash_busy) begin
                if (lat == 4'd0) begin
                    flash_busy <= 1'b0;
                    flash_data <= word_at(ptr);
                    ptr        <= ptr + 16'd4;
                    n_words    <= n_words + 1;
                end else begin
                    lat <= lat - 4'd1;
                end
            end else if (div == 3'd7) begin
                if (flash_start_read) begin
                    ptr        <= flash_addr;
                    flash_busy <= 1'b1;
                    lat        <= 4'(LAT);
                end else if (flash_continue_read) begin
                    flash_busy <= 1'b1;
                    lat        <= 4'(LAT);
                end
            end
        end
    end

    // monitor: request edges, done pulses, consumed samples, stop_read run length
    int         n_start = 0, n_cont = 0, n_done = 0, got_n = 0, stop_run = 0, stop_last = 0;
    logic [7:0] got [0:GOT_MAX-1];
    logic       start_p = 1'b0, cont_p = 1'b0;

    always @(negedge clk) begin
        if (flash_start_read && !start_p) n_start <= n_start + 1;
        if (flash_continue_read && !cont_p) n_cont <= n_cont + 1;
        start_p <= flash_start_read;
        cont_p  <= flash_continue_read;
        if (done) n_done <= n_done + 1;
        if (sample_strobe && sample_valid && got_n < GOT_MAX) begin
            got[got_n] <= sample_out;
            got_n      <= got_n + 1;
        end
        if (flash_stop_read) begin
            stop_run <= stop_run + 1;
        end else begin
            if (stop_run != 0) stop_last <= stop_run;
            stop_run <= 0;
        end
    end

    // strobe generator
    int strb_mode = 0;
    int period    = 1;
    int scyc      = 0;

    initial begin
        sample_strobe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            scyc = scyc + 1;
            case (strb_mode)
                1:       sample_strobe = ((scyc % period) == 0);
                2:       sample_strobe = ($urandom_range(32'(period - 1), 0) == 0);
                default: sample_strobe = 1'b0;
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] out_bus();
        return {sample_out, sample_valid, playing, underrun, done, flash_addr,
                flash_start_read, flash_continue_read, flash_stop_read};
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 200 && playing; k++) @(negedge clk);
        @(negedge clk);
        check({tag, " playing_low"}, 64'(playing), 64'd0);
    endtask

    task automatic run_case(input case_t t, input string tag);
        int g0, s0, c0, d0, k, bad;
        g0 = got_n; s0 = n_start; c0 = n_cont; d0 = n_done;
        base_addr    = t.base;
        length_words = 12'(t.len);
        period       = t.period;
        enable       = 1'b1;
        if (t.early) begin
            strb_mode = t.mode;
        end else begin
            for (k = 0; k < 2000 && !sample_valid && n_done == d0; k++) @(negedge clk);
            strb_mode = t.mode;
        end
        for (k = 0; k < 6000 && n_done == d0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, " done_count"}, 64'(n_done - d0), 64'd1);
        if (t.exp_und >= 0) check({tag, " underrun"}, 64'(underrun), 64'(t.exp_und));
        strb_mode = 0;
        enable    = 1'b0;
        wait_idle(tag);
        check({tag, " sample_count"}, 64'(got_n - g0), 64'(t.len * SPW));
        bad = 0;
        for (int i = 0; i < t.len * int'(SPW) && (g0 + i) < int'(GOT_MAX); i++) begin
            if (got[g0 + i] !== mem[16'(int'(t.base) + i)]) bad++;
        end
        check({tag, " data_errors"}, 64'(bad), 64'd0);
        check({tag, " start_reads"}, 64'(n_start - s0), 64'(t.exp_start));
        check({tag, " cont_reads"}, 64'(n_cont - c0), 64'(t.exp_cont));
        if (t.len > 0) check({tag, " stop_hold"}, 64'(stop_last), 64'(STOP_HOLD));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t cases [5];
        case_t rc;
        int    k, s0, c0, d0, w0, g0, bad;
        logic [7:0] pat [4];

        rst = 1'b1; enable = 1'b0; base_addr = '0; length_words = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'(i + 1);

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(out_bus()), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef STREAMER_LOOP_EN
        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC; pat[3] = 8'hDD;
        for (int i = 0; i < 4; i++) mem[16'h0200 + i] = pat[i];
        d0 = n_done; g0 = got_n;
        base_addr = 16'h0200; length_words = 12'd1; period = 3; strb_mode = 1; enable = 1'b1;
        for (k = 0; k < 4000 && (got_n - g0) < 12; k++) @(negedge clk);
        check("loop sample_count", 64'((got_n - g0) >= 12), 64'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) if (got[g0 + i] !== pat[i % 4]) bad++;
        check("loop data_errors", 64'(bad), 64'd0);
        check("loop no_done", 64'(n_done - d0), 64'd0);
        strb_mode = 0; enable = 1'b0;
        wait_idle("loop");
`else
        cases[0] = '{base:16'h0100, len:2, period:8, mode:1, early:1'b0, exp_start:1, exp_cont:1, exp_und:0};
        cases[1] = '{base:16'h0040, len:0, period:4, mode:1, early:1'b0, exp_start:0, exp_cont:0, exp_und:0};
        cases[2] = '{base:16'h0200, len:4, period:1, mode:1, early:1'b1, exp_start:1, exp_cont:3, exp_und:1};
        cases[3] = '{base:16'h0FFE, len:3, period:8, mode:1, early:1'b0, exp_start:1, exp_cont:2, exp_und:0};
        cases[4] = '{base:16'hFFFA, len:3, period:8, mode:1, early:1'b0, exp_start:1, exp_cont:2, exp_und:0};
        for (int i = 0; i < 5; i++) run_case(cases[i], $sformatf("case%0d", i));

        // zero-length run finishes quickly without touching the flash
        s0 = n_start;
        base_addr = 16'h0040; length_words = 12'd0; enable = 1'b1;
        k = 0;
        while (k < 10 && !done) begin
            @(negedge clk);
            k++;
        end
        check("len0 done_latency", 64'(done && k <= 2), 64'd1);
        enable = 1'b0;
        wait_idle("len0");
        check("len0 no_start", 64'(n_start - s0), 64'd0);

        // enable drops during word 2 of 8
        s0 = n_start; c0 = n_cont; d0 = n_done; w0 = n_words;
        base_addr = 16'h0300; length_words = 12'd8; period = 2; strb_mode = 1; enable = 1'b1;
        for (k = 0; k < 3000 && !(n_cont > c0 && flash_busy); k++) @(negedge clk);
        enable = 1'b0;
        for (k = 0; k < 500 && !flash_stop_read; k++) @(negedge clk);
        check("abort stop_seen", 64'(flash_stop_read), 64'd1);
        check("abort valid_drop", 64'(sample_valid), 64'd0);
        wait_idle("abort");
        strb_mode = 0;
        @(negedge clk);
        check("abort words_done", 64'(n_words - w0), 64'd2);
        check("abort stop_hold", 64'(stop_last), 64'(STOP_HOLD));
        check("abort no_done", 64'(n_done - d0), 64'd0);
        check("abort cont_reads", 64'(n_cont - c0), 64'd1);

        // reset while a continue is being requested
        base_addr = 16'h0400; length_words = 12'd8; period = 2; strb_mode = 1; enable = 1'b1;
        for (k = 0; k < 3000 && !flash_continue_read; k++) @(negedge clk);
        check("rst_mid cont_seen", 64'(flash_continue_read), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_mid outputs", 64'(out_bus()), 64'd0);
        enable = 1'b0; strb_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rc = '{base:16'h0400, len:3, period:8, mode:1, early:1'b0, exp_start:1, exp_cont:2, exp_und:0};
        run_case(rc, "post_rst");

        for (int r = 0; r < 6; r++) begin
            rc.base      = 16'($urandom);
            rc.len       = int'($urandom_range(5, 1));
            rc.period    = int'($urandom_range(6, 1));
            rc.mode      = 2;
            rc.early     = 1'b1;
            rc.exp_start = 1;
            rc.exp_cont  = rc.len - 1;
            rc.exp_und   = -1;
            run_case(rc, $sformatf("rand%0d", r));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
